// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver:
// segment ordering, hex glyph table and the per-slot FSM state type.
package seg7_pkg;

  // Segment vectors are ordered {g,f,e,d,c,b,a}, bit 0 = segment a, active high.
  localparam int unsigned SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    GUARD,
    ON,
    OFF
  } slot_state_t;

  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] value);
    logic [SEG_W-1:0] seg;
    case (value)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to active-high segment pattern, with a blank override
// used for leading-zero suppression.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0]       i_value,
  input  logic             i_blank,
  output logic [SEG_W-1:0] o_seg
);

  always_comb begin
    o_seg = i_blank ? SEG_BLANK : hex_to_seg(i_value);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver: slot prescaler, digit scan, per-slot PWM FSM,
// frame-synchronous shadow/active digit registers and registered pad outputs.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned CLK_HZ     = 12_000_000,
  parameter int unsigned REFRESH_HZ = 1_000,
  parameter int unsigned PWM_BITS   = 4,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                    clk_system_i,
  input  logic                    reset_n_i,
  input  logic                    enable_i,
  input  logic                    mode_i,
  input  logic                    blank_lz_i,
  input  logic [PWM_BITS-1:0]     brightness_i,
  input  logic                    wr_valid_i,
  output logic                    wr_ready_o,
  input  logic [8*NUM_DIGITS-1:0] wr_data_i,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic                    frame_o
);

  localparam int unsigned SLOT  = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int unsigned SUB   = SLOT >> PWM_BITS;
  localparam int unsigned CNT_W = $clog2(SLOT);
  localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  if ((NUM_DIGITS < 1) || (SLOT * REFRESH_HZ * NUM_DIGITS != CLK_HZ) ||
      (SUB * (1 << PWM_BITS) != SLOT) || (SUB < 2)) begin : g_bad_params
    $error("seg7_scan_driver: slot or subslot length is not an exact integer >= 2");
  end

  logic [CNT_W-1:0]          r_cnt;
  logic [DIG_W-1:0]          r_dig;
  slot_state_t               r_state;
  logic [PWM_BITS-1:0]       r_bright;
  logic                      r_frame;
  logic                      r_pending;
  logic [8*NUM_DIGITS-1:0]   r_shadow;
  logic [8*NUM_DIGITS-1:0]   r_active;
  logic [NUM_DIGITS-1:0]     r_an;
  logic [SEG_W-1:0]          r_seg;
  logic                      r_dp;

  logic                      w_cnt_last;
  logic                      w_dig_last;
  logic [CNT_W-1:0]          w_cnt_next;
  logic [31:0]               w_on_end;
  logic                      w_copy;
  logic [8*NUM_DIGITS-1:0]   w_src;
  logic [7:0]                w_byte;
  logic                      w_run;
  logic                      w_blank;
  logic                      w_lit;
  logic [NUM_DIGITS-1:0]     w_an_hot;
  logic [SEG_W-1:0]          w_hex_seg;
  logic [SEG_W-1:0]          w_seg;

  assign w_cnt_last = (r_cnt == CNT_W'(SLOT - 1));
  assign w_dig_last = (r_dig == DIG_W'(NUM_DIGITS - 1));
  assign w_cnt_next = w_cnt_last ? '0 : r_cnt + CNT_W'(1);
  assign w_on_end   = (32'(r_bright) + 32'd1) * SUB;
  assign w_lit      = enable_i & (r_state == ON);

  // The copy lands on the same edge that loads slot 0's guard outputs, so the
  // decode reads the shadow directly in that cycle to show the new frame at once.
  assign w_copy = r_frame & r_pending;
  assign w_src  = w_copy ? r_shadow : r_active;

  always_comb begin
    w_byte   = '0;
    w_blank  = 1'b0;
    w_run    = 1'b1;
    w_an_hot = '0;
    for (int unsigned i = NUM_DIGITS; i > 0; i--) begin
      w_run = w_run & (w_src[8*(i-1) +: 4] == 4'h0);
      if (DIG_W'(i - 1) == r_dig) begin
        w_byte        = w_src[8*(i-1) +: 8];
        w_blank       = w_run & (i > 1) & ~mode_i & blank_lz_i;
        w_an_hot[i-1] = w_lit;
      end
    end
  end

  seg7_hex_decode u_hex_decode (
    .i_value (w_byte[3:0]),
    .i_blank (w_blank),
    .o_seg   (w_hex_seg)
  );

  assign w_seg = mode_i ? w_byte[6:0] : w_hex_seg;

  always_ff @(posedge clk_system_i) begin
    if (!reset_n_i) begin
      r_cnt     <= '0;
      r_dig     <= '0;
      r_state   <= GUARD;
      r_bright  <= '0;
      r_frame   <= 1'b0;
      r_pending <= 1'b0;
      r_shadow  <= '0;
      r_active  <= '0;
      r_an      <= {NUM_DIGITS{ACTIVE_LOW}};
      r_seg     <= {SEG_W{ACTIVE_LOW}};
      r_dp      <= ACTIVE_LOW;
    end else begin
      r_cnt   <= w_cnt_next;
      r_frame <= w_cnt_last & w_dig_last;
      if (w_cnt_last) begin
        r_dig <= w_dig_last ? '0 : r_dig + DIG_W'(1);
      end

      case (r_state)
        GUARD: begin
          r_bright <= brightness_i;
          r_state  <= ON;
        end
        ON: begin
          if (w_cnt_last) begin
            r_state <= GUARD;
          end else if (32'(w_cnt_next) == w_on_end) begin
            r_state <= OFF;
          end
        end
        OFF: begin
          if (w_cnt_last) begin
            r_state <= GUARD;
          end
        end
        default: r_state <= GUARD;
      endcase

      if (w_copy) begin
        r_active  <= r_shadow;
        r_pending <= 1'b0;
      end else if (wr_valid_i && !r_pending) begin
        r_shadow  <= wr_data_i;
        r_pending <= 1'b1;
      end

      r_an  <= w_an_hot ^ {NUM_DIGITS{ACTIVE_LOW}};
      r_seg <= w_seg ^ {SEG_W{ACTIVE_LOW}};
      r_dp  <= w_byte[7] ^ ACTIVE_LOW;
    end
  end

  assign wr_ready_o = ~r_pending;
  assign an_o       = r_an;
  assign seg_o      = r_seg;
  assign dp_o       = r_dp;
  assign frame_o    = r_frame;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: SLOT=64, SUB=4, four digits, active-low pads.
// Expected outputs come from a position-based model of the scan and frame-applied writes.
module tb_seg7_scan_driver;

  localparam int HMAX = 16384;
  localparam int SLOT = 64;
  localparam int SUB  = 4;
  localparam int FRM  = 256;
  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic        mode = 1'b0;
  logic        blz = 1'b0;
  logic [3:0]  bright = 4'd15;
  logic        valid = 1'b0;
  logic [31:0] wdata = '0;
  logic        ready;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame;

  seg7_scan_driver #(
    .NUM_DIGITS (4),
    .CLK_HZ     (6400),
    .REFRESH_HZ (25),
    .PWM_BITS   (4),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk_system_i (clk),
    .reset_n_i    (reset_n),
    .enable_i     (enable),
    .mode_i       (mode),
    .blank_lz_i   (blz),
    .brightness_i (bright),
    .wr_valid_i   (valid),
    .wr_ready_o   (ready),
    .wr_data_i    (wdata),
    .an_o         (an),
    .seg_o        (seg),
    .dp_o         (dp),
    .frame_o      (frame)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit         en_h   [HMAX];
  bit         mode_h [HMAX];
  bit         blz_h  [HMAX];
  logic [3:0] br_h   [HMAX];

  int          upd_pos  [$];
  logic [31:0] upd_data [$];
  int          last_acc   = -1;
  int          last_apply = -1;

  function automatic bit model_ready(input int c);
    return !(last_acc >= 0 && last_acc < c && c <= last_apply);
  endfunction

  function automatic logic [31:0] content(input int q);
    logic [31:0] r = '0;
    for (int i = 0; i < upd_pos.size(); i++) if (upd_pos[i] <= q) r = upd_data[i];
    return r;
  endfunction

  // Output in cycle c reflects scan position c-1; frames start at multiples of 256.
  function automatic logic [13:0] exp_vec(input int c);
    int q, s, d, b;
    logic [31:0] w;
    logic [7:0]  by;
    logic [3:0]  a;
    logic [6:0]  sg;
    logic        lit, blank;
    if (c == 0) return {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1};
    q = c - 1;
    s = q % SLOT;
    d = (q / SLOT) % 4;
    b = int'(br_h[q - s]);
    lit = en_h[q] && s >= 1 && s < (b + 1) * SUB;
    a = lit ? ~(4'b0001 << d) : 4'hF;
    w = content(q);
    by = w[8*d +: 8];
    blank = !mode_h[q] && blz_h[q] && d != 0;
    for (int j = d; j < 4; j++) if (w[8*j +: 4] != 4'h0) blank = 1'b0;
    sg = mode_h[q] ? by[6:0] : (blank ? 7'h00 : GLYPH[by[3:0]]);
    return {a, ~sg, ~by[7], (c % FRM == 0), model_ready(c)};
  endfunction

  function automatic logic [13:0] obs_vec();
    return {an, seg, dp, frame, ready};
  endfunction

  task automatic tick();
    bit acc;
    if (cyc >= HMAX) begin
      $display("FAIL history cyc=%0d got=overflow exp=<%0d", cyc, HMAX);
      $fatal(1);
    end
    en_h[cyc] = enable; mode_h[cyc] = mode; blz_h[cyc] = blz; br_h[cyc] = bright;
    acc = valid && model_ready(cyc);
    if (acc) begin
      last_acc   = cyc;
      last_apply = (cyc / FRM + 1) * FRM;
      upd_pos.push_back(last_apply);
      upd_data.push_back(wdata);
    end
    @(posedge clk); #1;
    cyc++;
    if (acc) valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc = 0;
    upd_pos.delete();
    upd_data.delete();
    last_acc = -1;
    last_apply = -1;
  endtask

  task automatic test_reset();
    logic [13:0] ev, ov;
    enable = 1'b1; bright = 4'd15; mode = 1'b0; blz = 1'b0;
    do_reset();
    total++;
    if (obs_vec() !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
      bad++; $display("FAIL reset_state got=%h exp=%h", obs_vec(), {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1});
    end
    repeat (2 * FRM + 4) begin
      tick();
      ev = exp_vec(cyc); ov = obs_vec(); total++;
      if (ov !== ev) begin bad++; $display("FAIL scan cyc=%0d got=%h exp=%h", cyc, ov, ev); end
      if (cyc == 65 || cyc == 66 || cyc == 130 || cyc == 194) begin
        total++;
        if (an !== (cyc == 65 ? 4'hF : cyc == 66 ? 4'hD : cyc == 130 ? 4'hB : 4'h7)) begin
          bad++; $display("FAIL scan_order cyc=%0d got=%b", cyc, an);
        end
      end
    end
  endtask

  task automatic test_hex_write();
    logic [13:0] ev, ov;
    mode = 1'b0; blz = 1'b0; bright = 4'd15;
    valid = 1'b1; wdata = 32'h0F0A8301;
    for (int i = 0; i < 700; i++) begin
      tick();
      ev = exp_vec(cyc); ov = obs_vec(); total++;
      if (ov !== ev) begin bad++; $display("FAIL hex_write cyc=%0d got=%h exp=%h", cyc, ov, ev); end
      if (cyc == last_apply + 2) begin
        total++;
        if ({seg, dp} !== {7'b1111001, 1'b1}) begin
          bad++; $display("FAIL hex_digit0 got=%b exp=%b", {seg, dp}, {7'b1111001, 1'b1});
        end
      end
      if (cyc == last_apply + 66) begin
        total++;
        if ({seg, dp} !== {7'b0110000, 1'b0}) begin
          bad++; $display("FAIL hex_digit1 got=%b exp=%b", {seg, dp}, {7'b0110000, 1'b0});
        end
      end
    end
  endtask

  task automatic test_brightness();
    logic [13:0] ev, ov;
    int lit_n = 0, seen = 0;
    bright = 4'd3;
    repeat (300) begin
      tick();
      ev = exp_vec(cyc); ov = obs_vec(); total++;
      if (ov !== ev) begin bad++; $display("FAIL bright3 cyc=%0d got=%h exp=%h", cyc, ov, ev); end
      if ((cyc - 1) % SLOT == 0) seen++;
      if (seen == 2 && an !== 4'hF) lit_n++;
    end
    total++;
    if (lit_n !== 15) begin bad++; $display("FAIL bright3_width got=%0d exp=15", lit_n); end
    repeat (700) begin
      if ($urandom_range(0, 49) == 0) bright = 4'($urandom_range(0, 15));
      tick();
      ev = exp_vec(cyc); ov = obs_vec(); total++;
      if (ov !== ev) begin bad++; $display("FAIL bright_rand cyc=%0d got=%h exp=%h", cyc, ov, ev); end
    end
  endtask

  task automatic test_blanking();
    logic [13:0] ev, ov;
    int ap;
    bright = 4'd15; mode = 1'b0; blz = 1'b1;
    valid = 1'b1; wdata = 32'h00000500;
    for (int i = 0; i < 800; i++) begin
      tick();
      ap = last_apply;
      ev = exp_vec(cyc); ov = obs_vec(); total++;
      if (ov !== ev) begin bad++; $display("FAIL blank_lz cyc=%0d got=%h exp=%h", cyc, ov, ev); end
      if (cyc == ap + 198) begin
        total++;
        if ({an, seg} !== {4'b0111, 7'h7F}) begin
          bad++; $display("FAIL blank_digit3 got=%b exp=%b", {an, seg}, {4'b0111, 7'h7F});
        end
      end
      if (cyc == ap + 70) begin
        total++;
        if ({an, seg} !== {4'b1101, 7'b0010010}) begin
          bad++; $display("FAIL blank_digit1 got=%b exp=%b", {an, seg}, {4'b1101, 7'b0010010});
        end
      end
      if (cyc == ap + 300) blz = 1'b0;
      if (cyc == ap + 454) begin
        total++;
        if ({an, seg} !== {4'b0111, 7'b1000000}) begin
          bad++; $display("FAIL unblank_digit3 got=%b exp=%b", {an, seg}, {4'b0111, 7'b1000000});
        end
      end
    end
    repeat (3) begin
      valid = 1'b1;
      wdata = $urandom >> (8 * $urandom_range(0, 3));
      blz = 1'($urandom_range(0, 1));
      repeat (400) begin
        if ($urandom_range(0, 99) == 0) mode = ~mode;
        tick();
        ev = exp_vec(cyc); ov = obs_vec(); total++;
        if (ov !== ev) begin bad++; $display("FAIL blank_rand cyc=%0d got=%h exp=%h", cyc, ov, ev); end
      end
    end
    mode = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [13:0] ev, ov;
    int f;
    for (int i = 0; i < 2 * FRM && !(cyc % FRM == 0 && model_ready(cyc)); i++) begin
      tick();
      ev = exp_vec(cyc); ov = obs_vec(); total++;
      if (ov !== ev) begin bad++; $display("FAIL b2b_align cyc=%0d got=%h exp=%h", cyc, ov, ev); end
    end
    f = cyc;
    total++;
    if (frame !== 1'b1) begin bad++; $display("FAIL b2b_frame_start got=%b exp=1", frame); end
    valid = 1'b1; wdata = $urandom;
    tick();
    valid = 1'b1; wdata = $urandom;
    repeat (800) begin
      ev = exp_vec(cyc); ov = obs_vec(); total++;
      if (ov !== ev) begin bad++; $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, ov, ev); end
      if (cyc == f + 1 || cyc == f + 256 || cyc == f + 257 || cyc == f + 258) begin
        total++;
        if (ready !== (cyc == f + 257)) begin
          bad++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", cyc - f, ready, cyc == f + 257);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_midslot();
    logic [13:0] ev, ov;
    valid = 1'b1; wdata = $urandom | 32'h0000_0001;
    for (int i = 0; i < 200 && !(!valid && (cyc - 1) % SLOT == 20); i++) begin
      tick();
      ev = exp_vec(cyc); ov = obs_vec(); total++;
      if (ov !== ev) begin bad++; $display("FAIL pre_reset cyc=%0d got=%h exp=%h", cyc, ov, ev); end
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({an, seg, dp, frame, ready} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
      bad++; $display("FAIL midslot_reset got=%h exp=%h", obs_vec(), {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1});
    end
    do_reset();
    repeat (600) begin
      tick();
      ev = exp_vec(cyc); ov = obs_vec(); total++;
      if (ov !== ev) begin bad++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", cyc, ov, ev); end
      if (cyc == 300) begin
        total++;
        if (seg !== 7'b1000000) begin bad++; $display("FAIL post_reset_zero got=%b exp=1000000", seg); end
      end
    end
    enable = 1'b0;
    repeat (300) begin
      tick();
      ev = exp_vec(cyc); ov = obs_vec(); total++;
      if (ov !== ev) begin bad++; $display("FAIL disabled cyc=%0d got=%h exp=%h", cyc, ov, ev); end
      if (cyc > 1100) begin
        total++;
        if (an !== 4'hF) begin bad++; $display("FAIL disabled_an cyc=%0d got=%b exp=1111", cyc, an); end
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_random();
    logic [13:0] ev, ov;
    repeat (1500) begin
      if (!valid && $urandom_range(0, 99) < 2) begin valid = 1'b1; wdata = $urandom; end
      if ($urandom_range(0, 49) == 0) bright = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) mode = ~mode;
      if ($urandom_range(0, 99) == 0) blz = ~blz;
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      tick();
      ev = exp_vec(cyc); ov = obs_vec(); total++;
      if (ov !== ev) begin bad++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, ov, ev); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_hex_write();
    test_brightness();
    test_blanking();
    test_back_to_back();
    test_reset_midslot();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
